// File: rtl/span_packer_pkg.sv
// Shared types and helpers for the span packer: close-cause encoding and
// close-event accounting.
package span_packer_pkg;

  typedef enum logic [1:0] {
    CLOSE_NONE,
    CLOSE_SPLIT,
    CLOSE_FLUSH,
    CLOSE_IDLE
  } close_e;

  // Number of spans closed in one cycle (old span and/or freshly placed span).
  function automatic logic [1:0] close_weight(input logic close_old, input logic close_new);
    return {1'b0, close_old} + {1'b0, close_new};
  endfunction

endpackage

// File: rtl/span_packer_if.sv
// Pixel-in / descriptor-out / span-readback bus of the span packer.
interface span_packer_if #(
  parameter int XW        = 16,
  parameter int YW        = 16,
  parameter int PW        = 32,
  parameter int N_BUFS    = 4,
  parameter int BUF_DEPTH = 256
);
  localparam int SLOT_W = $clog2(N_BUFS);
  localparam int LEN_W  = $clog2(BUF_DEPTH + 1);
  localparam int ADDR_W = $clog2(BUF_DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic [PW-1:0]     in_data;
  logic              in_flush;
  logic              desc_valid;
  logic              desc_ready;
  logic [XW-1:0]     desc_x0;
  logic [YW-1:0]     desc_y;
  logic [LEN_W-1:0]  desc_len;
  logic [SLOT_W-1:0] desc_slot;
  logic              desc_done;
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [PW-1:0]     read_data;

  modport slave (
    input  in_valid, in_x, in_y, in_data, in_flush, desc_ready, desc_done, read_en, read_addr,
    output in_ready, desc_valid, desc_x0, desc_y, desc_len, desc_slot, read_data
  );

  modport master (
    output in_valid, in_x, in_y, in_data, in_flush, desc_ready, desc_done, read_en, read_addr,
    input  in_ready, desc_valid, desc_x0, desc_y, desc_len, desc_slot, read_data
  );
endinterface

// File: rtl/span_packer_bram.sv
// Simple dual-port RAM: write port A, registered read port B that holds its
// output while no read is requested.
module span_packer_bram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_p1;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read stage boundary: one cycle of latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rd_data_p1 <= '0;
    else if (re) rd_data_p1 <= mem[raddr];
  end

  assign rdata = rd_data_p1;
endmodule

// File: rtl/span_packer.sv
// Groups raster pixels into contiguous same-row spans held in a slot ring and
// emits one descriptor per closed span; slots cycle free->open->closed->in_use.
module span_packer
  import span_packer_pkg::*;
#(
  parameter int XW           = 16,
  parameter int YW           = 16,
  parameter int PW           = 32,
  parameter int N_BUFS       = 4,
  parameter int BUF_DEPTH    = 256,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CHECK_X      = 1
) (
  input  logic              clk,
  input  logic              rstn,
  span_packer_if.slave      bus,
  output logic              busy,
  output logic [15:0]       stat_spans
);
  localparam int SLOT_W = $clog2(N_BUFS);
  localparam int LEN_W  = $clog2(BUF_DEPTH + 1);
  localparam int ADDR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W  = $clog2(N_BUFS + 1);
  localparam int IDLE_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  logic              open_q;
  logic [SLOT_W-1:0] cur_slot, free_head, closed_head, inuse_head;
  logic [LEN_W-1:0]  cur_len;
  logic [XW-1:0]     cur_x0;
  logic [YW-1:0]     cur_y;
  logic [CNT_W-1:0]  free_count, closed_count, in_use_count;
  logic [IDLE_W-1:0] idle_cnt;

  logic [XW-1:0]     meta_x0  [N_BUFS];
  logic [YW-1:0]     meta_y   [N_BUFS];
  logic [LEN_W-1:0]  meta_len [N_BUFS];

  logic              x_ok, append, in_ready, accept, new_span, timeout_hit;
  logic              close_old, close_new, pop, rel;
  logic [1:0]        n_close;
  logic [XW-1:0]     x_next, x0_after;
  logic [LEN_W-1:0]  len_after;
  logic [SLOT_W-1:0] new_slot;
  logic [ADDR_W-1:0] wr_off;
  close_e            close_cause;

  assign x_next      = cur_x0 + XW'(cur_len);
  assign x_ok        = (CHECK_X == 0) || (bus.in_x == x_next);
  assign append      = open_q && (bus.in_y == cur_y) && x_ok && (cur_len < LEN_W'(BUF_DEPTH));
  assign in_ready    = append || (free_count != '0);
  assign accept      = bus.in_valid && in_ready;
  assign new_span    = accept && !append;
  assign timeout_hit = (IDLE_TIMEOUT != 0) && open_q && !bus.in_valid &&
                       (idle_cnt == IDLE_W'(IDLE_TIMEOUT));

  // A pixel that cannot append always retires the open span first; a flush or
  // idle timeout only closes it when no pixel is placed this cycle.
  always_comb begin
    close_cause = CLOSE_NONE;
    if (open_q) begin
      if (new_span)                    close_cause = CLOSE_SPLIT;
      else if (!accept && bus.in_flush) close_cause = CLOSE_FLUSH;
      else if (timeout_hit)            close_cause = CLOSE_IDLE;
    end
  end

  assign close_old = (close_cause != CLOSE_NONE);
  assign close_new = accept && bus.in_flush;
  assign n_close   = close_weight(close_old, close_new);
  assign pop       = bus.desc_valid && bus.desc_ready;
  assign rel       = bus.desc_done && (in_use_count != '0);

  assign new_slot  = append ? cur_slot : free_head;
  assign wr_off    = append ? cur_len[ADDR_W-1:0] : '0;
  assign len_after = append ? cur_len + LEN_W'(1) : LEN_W'(1);
  assign x0_after  = append ? cur_x0 : bus.in_x;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      open_q       <= 1'b0;
      cur_slot     <= '0;
      cur_len      <= '0;
      free_head    <= '0;
      closed_head  <= '0;
      inuse_head   <= '0;
      free_count   <= CNT_W'(N_BUFS);
      closed_count <= '0;
      in_use_count <= '0;
      idle_cnt     <= '0;
      stat_spans   <= '0;
    end else begin
      // Net updates so simultaneous alloc/close/pop/release all land
      free_count   <= free_count - CNT_W'(new_span) + CNT_W'(rel);
      closed_count <= closed_count + CNT_W'(n_close) - CNT_W'(pop);
      in_use_count <= in_use_count + CNT_W'(pop) - CNT_W'(rel);
      free_head    <= free_head + SLOT_W'(new_span);
      closed_head  <= closed_head + SLOT_W'(pop);
      inuse_head   <= inuse_head + SLOT_W'(rel);
      stat_spans   <= stat_spans + 16'(n_close);
      open_q       <= new_span ? !bus.in_flush : (open_q && !(close_old || close_new));
      if (accept) begin
        cur_slot <= new_slot;
        cur_len  <= len_after;
      end
      if (accept || !open_q || close_old) idle_cnt <= '0;
      else if (!bus.in_valid)             idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (new_span) begin
      cur_x0 <= bus.in_x;
      cur_y  <= bus.in_y;
    end
    if (close_old) begin
      meta_x0[cur_slot]  <= cur_x0;
      meta_y[cur_slot]   <= cur_y;
      meta_len[cur_slot] <= cur_len;
    end
    if (close_new) begin
      meta_x0[new_slot]  <= x0_after;
      meta_y[new_slot]   <= bus.in_y;
      meta_len[new_slot] <= len_after;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.desc_valid = (closed_count != '0);
  assign bus.desc_x0    = bus.desc_valid ? meta_x0[closed_head]  : '0;
  assign bus.desc_y     = bus.desc_valid ? meta_y[closed_head]   : '0;
  assign bus.desc_len   = bus.desc_valid ? meta_len[closed_head] : '0;
  assign bus.desc_slot  = bus.desc_valid ? closed_head           : '0;
  assign busy           = open_q || (free_count != CNT_W'(N_BUFS));

  span_packer_bram #(
    .DW    (PW),
    .DEPTH (N_BUFS * BUF_DEPTH)
  ) u_bram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (accept),
    .waddr ({new_slot, wr_off}),
    .wdata (bus.in_data),
    .re    (bus.read_en && (in_use_count != '0)),
    .raddr ({inuse_head, bus.read_addr}),
    .rdata (bus.read_data)
  );
endmodule
